// File: rtl/instr_mem_obi_slave.sv
// -----------------------------------------------------------------------------
// instr_mem_obi_slave
//
// OBI instruction-memory responder for the cv32e40p fetch port. Requests are
// granted combinationally. Each accepted request reads one 32-bit word, which
// is returned RD_LATENCY cycles later through a fixed valid/data shift
// pipeline. A side-band load port preloads the program image.
//
// Handshake semantics:
//   A request is accepted at a rising edge where instr_req_i && instr_gnt_o.
//   Exactly one instr_rvalid_o pulse follows each accepted request, in order,
//   RD_LATENCY cycles after the accepting edge. OBI has no rready, so the
//   response pipeline never stalls. The grant is withheld whenever the
//   outstanding limit is reached, a preload write is in progress, or the
//   optional wait-state generator asks for a stall.
//
// Parameters:
//   ADDR_WIDTH       word-address bits (memory depth 2**ADDR_WIDTH words)
//   RD_LATENCY       accepted-request-to-rvalid latency, legal 1..4
//   MAX_OUTSTANDING  accepted but unanswered requests allowed, legal 1..4
//
// Ports:
//   clk_i           clock, rising edge
//   rst_n           asynchronous active-low reset
//   instr_req_i     fetch request
//   instr_addr_i    fetch byte address (bits [ADDR_WIDTH+1:2] index the memory)
//   instr_gnt_o     request accepted this cycle
//   instr_rvalid_o  response valid
//   instr_rdata_o   response data; holds its last value while rvalid is low
//   load_we_i       preload write strobe (has priority over fetches)
//   load_addr_i     preload word address
//   load_wdata_i    preload data
//   misalign_err_o  sticky: an accepted request had addr[1:0] != 0
//
// Optional build macro:
//   INSTR_MEM_GNT_STALL_EN  when defined, an 8-bit Fibonacci LFSR
//                           (taps 8,6,5,4, seed 8'hA5) withholds the grant on
//                           roughly a quarter of the cycles to emulate wait
//                           states. When undefined, no stalls are inserted.
// -----------------------------------------------------------------------------
module instr_mem_obi_slave #(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [31:0]           load_wdata_i,
  output logic                  misalign_err_o
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [2:0]  MAX_OUT = 3'(MAX_OUTSTANDING);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];

  // Preload writes. Memory is deliberately not reset so that a program image
  // survives a core reset.
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant / accept
  // ---------------------------------------------------------------------------
  logic                  stall;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic [2:0]            outstanding_q;
  logic [2:0]            outstanding_d;

  // Upper address bits are ignored so that fetches wrap modulo the memory
  // size; the byte-offset bits only feed the misalignment flag.
  assign fetch_idx = instr_addr_i[ADDR_WIDTH+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^instr_addr_i[31:ADDR_WIDTH+2];

  assign instr_gnt_o = instr_req_i && !load_we_i &&
                       (outstanding_q < MAX_OUT) && !stall;
  assign accept      = instr_req_i && instr_gnt_o;

`ifdef INSTR_MEM_GNT_STALL_EN
  // Wait-state generator: free-running maximal-length LFSR. A stall only
  // withholds the grant; responses already in flight are unaffected.
  logic [7:0] lfsr_q;
  logic       lfsr_fb;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outstanding-transaction counter
  // ---------------------------------------------------------------------------
  // A response leaving and a request entering in the same cycle cancel out.
  // The counter cannot underflow because rvalid only exists for an accepted
  // request, and cannot exceed the limit because the grant is gated on it.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !instr_rvalid_o) begin
      outstanding_d = outstanding_q + 3'd1;
    end else if (!accept && instr_rvalid_o) begin
      outstanding_d = outstanding_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= 3'd0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------------
  // Stage 0 captures the memory word at the accepting edge. Each later stage
  // copies its data only when a valid word arrives, so the last stage (which
  // drives instr_rdata_o) holds its value between responses. Reset empties
  // the pipeline asynchronously, dropping any in-flight responses.
  logic [RD_LATENCY-1:0] valid_q;
  logic [31:0]           data_q [RD_LATENCY];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        data_q[i] <= 32'h0;
      end
    end else begin
      valid_q[0] <= accept;
      if (accept) begin
        data_q[0] <= mem[fetch_idx];
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign instr_rvalid_o = valid_q[RD_LATENCY-1];
  assign instr_rdata_o  = data_q[RD_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Sticky misalignment flag
  // ---------------------------------------------------------------------------
  // The misaligned access itself is still served with the containing word.
  logic misalign_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (accept && (instr_addr_i[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err_o = misalign_q;

  // ---------------------------------------------------------------------------
  // Embedded properties
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_outstanding_limit : assert property (
    @(posedge clk_i) disable iff (!rst_n) outstanding_q <= MAX_OUT);

  a_rvalid_has_request : assert property (
    @(posedge clk_i) disable iff (!rst_n) instr_rvalid_o |-> (outstanding_q != 3'd0));

  a_no_grant_during_load : assert property (
    @(posedge clk_i) disable iff (!rst_n) load_we_i |-> !instr_gnt_o);
`endif

endmodule

// File: tb/tb_instr_mem_obi_slave.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_obi_slave
//
// Directed bench for instr_mem_obi_slave. Three instances share one clock:
//   dut_a  defaults (RD_LATENCY=1, MAX_OUTSTANDING=2)
//   dut_b  RD_LATENCY=3, MAX_OUTSTANDING=1 (grant throttling)
//   dut_c  RD_LATENCY=2, MAX_OUTSTANDING=2 (reset with responses in flight)
// Inputs change on the falling edge; outputs are sampled 1 ns later, well
// away from the rising edge.
// -----------------------------------------------------------------------------
module tb_instr_mem_obi_slave;

  localparam int AW = 12;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_n;
  logic rst_c;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic          req_a, gnt_a, rvalid_a, lwe_a, mis_a;
  logic [31:0]   addr_a, rdata_a, lwdata_a;
  logic [AW-1:0] laddr_a;

  logic          req_b, gnt_b, rvalid_b, lwe_b, mis_b;
  logic [31:0]   addr_b, rdata_b, lwdata_b;
  logic [AW-1:0] laddr_b;

  logic          req_c, gnt_c, rvalid_c, lwe_c, mis_c;
  logic [31:0]   addr_c, rdata_c, lwdata_c;
  logic [AW-1:0] laddr_c;

  instr_mem_obi_slave #(.ADDR_WIDTH(AW), .RD_LATENCY(1), .MAX_OUTSTANDING(2)) dut_a (
    .clk_i(clk_i), .rst_n(rst_n),
    .instr_req_i(req_a), .instr_addr_i(addr_a), .instr_gnt_o(gnt_a),
    .instr_rvalid_o(rvalid_a), .instr_rdata_o(rdata_a),
    .load_we_i(lwe_a), .load_addr_i(laddr_a), .load_wdata_i(lwdata_a),
    .misalign_err_o(mis_a)
  );

  instr_mem_obi_slave #(.ADDR_WIDTH(AW), .RD_LATENCY(3), .MAX_OUTSTANDING(1)) dut_b (
    .clk_i(clk_i), .rst_n(rst_n),
    .instr_req_i(req_b), .instr_addr_i(addr_b), .instr_gnt_o(gnt_b),
    .instr_rvalid_o(rvalid_b), .instr_rdata_o(rdata_b),
    .load_we_i(lwe_b), .load_addr_i(laddr_b), .load_wdata_i(lwdata_b),
    .misalign_err_o(mis_b)
  );

  instr_mem_obi_slave #(.ADDR_WIDTH(AW), .RD_LATENCY(2), .MAX_OUTSTANDING(2)) dut_c (
    .clk_i(clk_i), .rst_n(rst_c),
    .instr_req_i(req_c), .instr_addr_i(addr_c), .instr_gnt_o(gnt_c),
    .instr_rvalid_o(rvalid_c), .instr_rdata_o(rdata_c),
    .load_we_i(lwe_c), .load_addr_i(laddr_c), .load_wdata_i(lwdata_c),
    .misalign_err_o(mis_c)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and checker
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Program images (hand-chosen expected data).
  logic [31:0] prog_a [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
  logic [31:0] prog_b [3] = '{32'h11110000, 32'h11110001, 32'h11110002};
  logic [31:0] prog_c [2] = '{32'hCAFE0000, 32'hCAFE0001};

  // ---------------------------------------------------------------------------
  // Driver tasks (each starts by waiting for the falling edge)
  // ---------------------------------------------------------------------------
  task automatic load_a(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk_i);
    lwe_a = 1'b1; laddr_a = a; lwdata_a = d;
  endtask

  task automatic load_b(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk_i);
    lwe_b = 1'b1; laddr_b = a; lwdata_b = d;
  endtask

  task automatic load_c(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk_i);
    lwe_c = 1'b1; laddr_c = a; lwdata_c = d;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; rst_c = 1'b0;
    req_a = 1'b0; addr_a = '0; lwe_a = 1'b0; laddr_a = '0; lwdata_a = '0;
    req_b = 1'b0; addr_b = '0; lwe_b = 1'b0; laddr_b = '0; lwdata_b = '0;
    req_c = 1'b0; addr_c = '0; lwe_c = 1'b0; laddr_c = '0; lwdata_c = '0;

    // Reset values.
    repeat (2) @(negedge clk_i);
    #1;
    check_eq("rst_gnt",      32'(gnt_a),    32'd0);
    check_eq("rst_rvalid",   32'(rvalid_a), 32'd0);
    check_eq("rst_rdata",    rdata_a,       32'd0);
    check_eq("rst_misalign", 32'(mis_a),    32'd0);
    check_eq("rst_b_rvalid", 32'(rvalid_b), 32'd0);
    check_eq("rst_b_rdata",  rdata_b,       32'd0);
    @(negedge clk_i);
    rst_n = 1'b1; rst_c = 1'b1;

    // Preload all three memories.
    for (int k = 0; k < 4; k++) load_a(AW'(k), prog_a[k]);
    for (int k = 0; k < 3; k++) load_b(AW'(k), prog_b[k]);
    for (int k = 0; k < 2; k++) load_c(AW'(k), prog_c[k]);
    @(negedge clk_i);
    lwe_a = 1'b0; lwe_b = 1'b0; lwe_c = 1'b0;

`ifdef INSTR_MEM_GNT_STALL_EN
    // Wait-state mode: hold a request for 256 cycles; with RD_LATENCY=1 each
    // rvalid must follow a grant in the previous cycle.
    begin
      int   acc;
      logic prev_gnt;
      acc = 0;
      prev_gnt = 1'b0;
      for (int t = 0; t < 256; t++) begin
        @(negedge clk_i);
        req_a = 1'b1; addr_a = 32'h0;
        #1;
        check_eq("stall_rvalid", 32'(rvalid_a), 32'(prev_gnt));
        if (rvalid_a) check_eq("stall_rdata", rdata_a, prog_a[0]);
        prev_gnt = gnt_a;
        if (gnt_a) acc++;
      end
      @(negedge clk_i);
      req_a = 1'b0;
      #1;
      check_eq("stall_last_rvalid", 32'(rvalid_a), 32'(prev_gnt));
      check_eq("stall_accept_range", 32'((acc >= 160) && (acc <= 224)), 32'd1);
    end
`else
    // Back-to-back fetch of 0x0, 0x4, 0x8, 0xC on dut_a.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      req_a = 1'b1; addr_a = 32'(4 * k);
      #1;
      check_eq("b2b_gnt", 32'(gnt_a), 32'd1);
      check_eq("b2b_rvalid", 32'(rvalid_a), 32'(k > 0));
      if (k > 0) check_eq("b2b_rdata", rdata_a, prog_a[k-1]);
      check_eq("b2b_outstanding", 32'(dut_a.outstanding_q), (k == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk_i);
    req_a = 1'b0;
    #1;
    check_eq("b2b_last_gnt",    32'(gnt_a),    32'd0);
    check_eq("b2b_last_rvalid", 32'(rvalid_a), 32'd1);
    check_eq("b2b_last_rdata",  rdata_a,       prog_a[3]);
    @(negedge clk_i);
    #1;
    check_eq("idle_rvalid",      32'(rvalid_a), 32'd0);
    check_eq("idle_rdata_hold",  rdata_a,       prog_a[3]);
    check_eq("idle_outstanding", 32'(dut_a.outstanding_q), 32'd0);

    // Misaligned, wrapping address: 0x4002 -> word 0.
    @(negedge clk_i);
    req_a = 1'b1; addr_a = 32'h0000_4002;
    #1;
    check_eq("mis_gnt",    32'(gnt_a), 32'd1);
    check_eq("mis_before", 32'(mis_a), 32'd0);
    @(negedge clk_i);
    req_a = 1'b0;
    #1;
    check_eq("mis_set",        32'(mis_a),    32'd1);
    check_eq("wrap_rvalid",    32'(rvalid_a), 32'd1);
    check_eq("wrap_rdata",     rdata_a,       prog_a[0]);
    repeat (3) @(negedge clk_i);
    #1;
    check_eq("mis_sticky", 32'(mis_a), 32'd1);

    // Load has priority over a simultaneous fetch.
    @(negedge clk_i);
    req_a = 1'b1; addr_a = 32'h8;
    lwe_a = 1'b1; laddr_a = AW'(2); lwdata_a = 32'hDEADBEEF;
    #1;
    check_eq("load_prio_gnt", 32'(gnt_a), 32'd0);
    @(negedge clk_i);
    lwe_a = 1'b0;
    #1;
    check_eq("after_load_gnt",    32'(gnt_a),    32'd1);
    check_eq("after_load_rvalid", 32'(rvalid_a), 32'd0);
    @(negedge clk_i);
    req_a = 1'b0;
    #1;
    check_eq("new_data_rvalid", 32'(rvalid_a), 32'd1);
    check_eq("new_data_rdata",  rdata_a,       32'hDEADBEEF);

    // dut_b: request held high; grant every 4th cycle (slot frees the cycle
    // after the response), response 3 cycles after the grant cycle.
    for (int t = 0; t < 12; t++) begin
      @(negedge clk_i);
      req_b = 1'b1; addr_b = 32'((t / 4) * 4);
      #1;
      check_eq("thr_gnt",    32'(gnt_b),    32'((t % 4) == 0));
      check_eq("thr_rvalid", 32'(rvalid_b), 32'((t % 4) == 3));
      if ((t % 4) == 3) check_eq("thr_rdata", rdata_b, prog_b[t / 4]);
      check_eq("thr_outstanding", 32'(dut_b.outstanding_q), ((t % 4) == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk_i);
    req_b = 1'b0;

    // dut_c: two requests in flight, then a reset pulse.
    @(negedge clk_i);
    req_c = 1'b1; addr_c = 32'h0;
    #1;
    check_eq("inflight_gnt0", 32'(gnt_c), 32'd1);
    @(negedge clk_i);
    addr_c = 32'h4;
    #1;
    check_eq("inflight_gnt1",   32'(gnt_c),    32'd1);
    check_eq("inflight_rvalid", 32'(rvalid_c), 32'd0);
    @(negedge clk_i);
    req_c = 1'b0;
    #1;
    check_eq("inflight_first_rvalid", 32'(rvalid_c), 32'd1);
    check_eq("inflight_first_rdata",  rdata_c,       prog_c[0]);
    check_eq("inflight_outstanding",  32'(dut_c.outstanding_q), 32'd2);
    rst_c = 1'b0;
    #1;
    check_eq("rstmid_rvalid",      32'(rvalid_c), 32'd0);
    check_eq("rstmid_rdata",       rdata_c,       32'd0);
    check_eq("rstmid_outstanding", 32'(dut_c.outstanding_q), 32'd0);
    @(negedge clk_i);
    rst_c = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk_i);
      #1;
      check_eq("no_late_rvalid", 32'(rvalid_c), 32'd0);
    end
    @(negedge clk_i);
    req_c = 1'b1; addr_c = 32'h4;
    #1;
    check_eq("post_rst_gnt", 32'(gnt_c), 32'd1);
    @(negedge clk_i);
    req_c = 1'b0;
    #1;
    check_eq("post_rst_lat_rvalid", 32'(rvalid_c), 32'd0);
    @(negedge clk_i);
    #1;
    check_eq("post_rst_rvalid", 32'(rvalid_c), 32'd1);
    check_eq("mem_kept_rdata",  rdata_c,       prog_c[1]);

    // Only reset clears the sticky misalignment flag.
    @(negedge clk_i);
    rst_n = 1'b0;
    #1;
    check_eq("mis_cleared", 32'(mis_a), 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
`endif

    repeat (2) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
